// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types, encoding constants and width helpers for the BNN layer engine
package bnn_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

   // Binary encoding of the +1/-1 values carried in feature and weight bits
   localparam logic POS = 1'b1;
   localparam logic NEG = 1'b0;

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int score_w(input int in_bits);
      return $clog2(in_bits + 1);
   endfunction

   function automatic int class_w(input int neurons);
      return cw(neurons);
   endfunction

   function automatic int addr_w(input int in_bits, input int neurons, input int chunk);
      return cw(neurons * in_bits / chunk);
   endfunction

endpackage

// File: rtl/bnn_layer_engine_if.sv
// rtl/bnn_layer_engine_if.sv - feature stream, weight memory and result handshake bundle
interface bnn_layer_engine_if #(
   parameter int IN_BITS = 64,
   parameter int NEURONS = 8,
   parameter int CHUNK   = 8
);
   import bnn_pkg::*;

   localparam int AW  = addr_w(IN_BITS, NEURONS, CHUNK);
   localparam int CLW = class_w(NEURONS);
   localparam int SW  = score_w(IN_BITS);

   logic [7:0]         in_data;
   logic               in_valid;
   logic               in_ready;
   logic [AW-1:0]      w_addr;
   logic               w_en;
   logic [CHUNK-1:0]   w_data;
   logic               out_valid;
   logic               out_ready;
   logic [CLW-1:0]     out_class;
   logic [SW-1:0]      out_score;
   logic [NEURONS-1:0] out_act;

   modport master (
      output in_data, in_valid, w_data, out_ready,
      input  in_ready, w_addr, w_en, out_valid, out_class, out_score, out_act
   );

   modport slave (
      input  in_data, in_valid, w_data, out_ready,
      output in_ready, w_addr, w_en, out_valid, out_class, out_score, out_act
   );

endinterface

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational count of ones over a W-bit word
module bnn_popcount #(
   parameter int W = 8
) (
   input  logic [W-1:0]              bits,
   output logic [$clog2(W+1)-1:0]    count
);
   localparam int CW = $clog2(W + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/bnn_layer_engine.sv
// rtl/bnn_layer_engine.sv - serial XNOR-popcount fully-connected layer with sign activations and argmax
module bnn_layer_engine
   import bnn_pkg::*;
#(
   parameter int IN_BITS = 64,
   parameter int NEURONS = 8,
   parameter int CHUNK   = 8
) (
   input logic              clk,
   input logic              rst,
   bnn_layer_engine_if.slave bus
);
   localparam int CHUNKS = IN_BITS / CHUNK;
   localparam int NC     = NEURONS * CHUNKS;
   localparam int BYTES  = IN_BITS / 8;
   localparam int SW     = score_w(IN_BITS);
   localparam int PW     = $clog2(CHUNK + 1);
   localparam int AW     = addr_w(IN_BITS, NEURONS, CHUNK);
   localparam int CLW    = class_w(NEURONS);
   localparam int KW     = cw(CHUNKS);
   localparam int BW     = cw(BYTES);
   localparam logic [SW-1:0]  HALF   = SW'(IN_BITS / 2);
   localparam logic [KW-1:0]  LAST_K = KW'(CHUNKS - 1);

   state_t              state;
   logic [IN_BITS-1:0]  in_reg;
   logic [BW-1:0]       byte_cnt;
   logic [CLW-1:0]      n_cnt;
   logic [KW-1:0]       k_cnt;
   logic                tag_valid;
   logic [CLW-1:0]      tag_n;
   logic [KW-1:0]       tag_k;
   logic [SW-1:0]       acc;

   logic [CHUNK-1:0]    match;
   logic [PW-1:0]       pc;
   logic [SW-1:0]       sum;

   // tag_* describe the word arriving on w_data this cycle (issued one cycle earlier)
   assign match = ~(bus.w_data ^ in_reg[tag_k*CHUNK +: CHUNK]);
   assign sum   = ((tag_k == '0) ? '0 : acc) + SW'(pc);

   bnn_popcount #(.W(CHUNK)) u_popcount (
      .bits  (match),
      .count (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= LOAD;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.w_en      <= 1'b0;
         bus.w_addr    <= '0;
         bus.out_class <= '0;
         bus.out_score <= '0;
         bus.out_act   <= '0;
         in_reg        <= '0;
         byte_cnt      <= '0;
         n_cnt         <= '0;
         k_cnt         <= '0;
         tag_valid     <= 1'b0;
         tag_n         <= '0;
         tag_k         <= '0;
         acc           <= '0;
      end else begin
         tag_valid <= bus.w_en;
         tag_n     <= n_cnt;
         tag_k     <= k_cnt;
         case (state)
            LOAD: begin
               if (bus.in_valid && bus.in_ready) begin
                  in_reg[byte_cnt*8 +: 8] <= bus.in_data;
                  if (byte_cnt == BW'(BYTES - 1)) begin
                     byte_cnt     <= '0;
                     bus.in_ready <= 1'b0;
                     bus.w_en     <= 1'b1;
                     bus.w_addr   <= '0;
                     n_cnt        <= '0;
                     k_cnt        <= '0;
                     state        <= COMPUTE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (bus.w_en) begin
                  if (bus.w_addr == AW'(NC - 1)) begin
                     bus.w_en <= 1'b0;
                  end else begin
                     bus.w_addr <= bus.w_addr + 1'b1;
                     if (k_cnt == LAST_K) begin
                        k_cnt <= '0;
                        n_cnt <= n_cnt + 1'b1;
                     end else begin
                        k_cnt <= k_cnt + 1'b1;
                     end
                  end
               end
               if (tag_valid) begin
                  acc <= sum;
                  if (tag_k == LAST_K) begin
                     bus.out_act[tag_n] <= (sum >= HALF) ? POS : NEG;
                     // strict compare keeps the lowest index on ties
                     if (tag_n == '0 || sum > bus.out_score) begin
                        bus.out_score <= sum;
                        bus.out_class <= tag_n;
                     end
                     if (tag_n == CLW'(NEURONS - 1)) begin
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (bus.out_valid && bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// tb/tb_bnn_layer_engine.sv - randomized and directed checks of bnn_layer_engine against a reference model
module tb_bnn_layer_engine;
   localparam int IN_BITS = 16;
   localparam int NEURONS = 4;
   localparam int CHUNK   = 8;
   localparam int NC      = NEURONS * IN_BITS / CHUNK;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bnn_layer_engine_if #(.IN_BITS(IN_BITS), .NEURONS(NEURONS), .CHUNK(CHUNK)) bif ();

   bnn_layer_engine #(.IN_BITS(IN_BITS), .NEURONS(NEURONS), .CHUNK(CHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          acc_cyc;
   int          wfirst;
   logic [15:0] wts [NEURONS];
   int          wq [$];
   int          exp_cls;
   int          exp_sc;
   logic [3:0]  exp_act;

   always @(posedge clk) cyc <= cyc + 1;

   // weight ROM with one cycle read latency
   always @(posedge clk) begin
      if (bif.w_en) bif.w_data <= wts[bif.w_addr >> 1][bif.w_addr[0]*8 +: 8];
   end

   always @(negedge clk) begin
      if (bif.w_en) begin
         if (wq.size() == 0) wfirst = cyc;
         wq.push_back(int'(bif.w_addr));
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [15:0] x);
      int s;
      exp_sc  = 0;
      exp_cls = 0;
      exp_act = '0;
      for (int j = 0; j < NEURONS; j++) begin
         s = $countones(~(x ^ wts[j]));
         exp_act[j] = (s >= IN_BITS / 2);
         if (j == 0 || s > exp_sc) begin
            exp_sc  = s;
            exp_cls = j;
         end
      end
   endfunction

   task automatic send_byte(input logic [7:0] d, input bit gap);
      int n = 0;
      bif.in_data  = d;
      bif.in_valid = 1'b1;
      while (!bif.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("in_ready_timeout", bif.in_ready, 1);
      @(negedge clk);
      acc_cyc      = cyc;
      bif.in_valid = 1'b0;
      bif.in_data  = 8'($urandom);
      if (gap) @(negedge clk);
   endtask

   task automatic load_vec(input logic [15:0] x, input bit gap);
      wq.delete();
      for (int b = 0; b < IN_BITS / 8; b++) send_byte(x[b*8 +: 8], gap);
   endtask

   task automatic finish_vec(input logic [15:0] x);
      int n = 0;
      bit seq_ok = 1'b1;
      while (!bif.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("out_valid_timeout", bif.out_valid, 1);
      check_eq("latency", cyc + 1 - acc_cyc, NC + 2);
      check_eq("w_en_start", wfirst - acc_cyc, 0);
      check_eq("w_en_count", wq.size(), NC);
      foreach (wq[i]) if (wq[i] != i) seq_ok = 1'b0;
      check_eq("w_addr_seq", seq_ok, 1);
      model(x);
      check_eq("out_class", bif.out_class, exp_cls);
      check_eq("out_score", bif.out_score, exp_sc);
      check_eq("out_act", bif.out_act, exp_act);
   endtask

   task automatic accept_out();
      bif.out_ready = 1'b1;
      @(negedge clk);
      bif.out_ready = 1'b0;
      check_eq("out_valid_clear", bif.out_valid, 0);
      check_eq("in_ready_back", bif.in_ready, 1);
   endtask

   task automatic rand_wts();
      for (int j = 0; j < NEURONS; j++) wts[j] = 16'($urandom);
   endtask

   initial begin
      logic [15:0] x;
      logic [31:0] hold_obs;
      logic [31:0] hold_exp;
      int          n;
      rst          = 1'b1;
      bif.in_valid = 1'b0;
      bif.in_data  = '0;
      bif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", bif.in_ready, 1);
      check_eq("rst_out_valid", bif.out_valid, 0);
      check_eq("rst_w_en", bif.w_en, 0);
      check_eq("rst_w_addr", bif.w_addr, 0);
      check_eq("rst_outputs", {bif.out_class, bif.out_score, bif.out_act}, 0);
      rst = 1'b0;
      @(negedge clk);

      wts = '{16'h0000, 16'h00FF, 16'hFFFF, 16'h0FFF};
      load_vec(16'hFFFF, 1'b0);
      finish_vec(16'hFFFF);
      check_eq("t1_class", bif.out_class, 2);
      check_eq("t1_score", bif.out_score, 16);
      check_eq("t1_act", bif.out_act, 4'b1110);
      accept_out();

      wts = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      load_vec(16'h0000, 1'b0);
      finish_vec(16'h0000);
      check_eq("t2_class", bif.out_class, 0);
      check_eq("t2_score", bif.out_score, 16);
      check_eq("t2_act", bif.out_act, 4'b1111);
      accept_out();

      wts = '{16'h0000, 16'h0000, 16'h0000, 16'h55AA};
      load_vec(16'h55AA, 1'b0);
      finish_vec(16'h55AA);
      check_eq("t3_class", bif.out_class, 3);
      check_eq("t3_score", bif.out_score, 16);
      accept_out();

      rand_wts();
      x = 16'($urandom);
      load_vec(x, 1'b0);
      finish_vec(x);
      hold_exp = {18'd0, 1'b1, 2'(exp_cls), 5'(exp_sc), exp_act, 1'b0};
      for (int i = 0; i < 20; i++) begin
         bif.in_valid = 1'b1;
         bif.in_data  = 8'($urandom);
         @(negedge clk);
         hold_obs = {18'd0, bif.out_valid, bif.out_class, bif.out_score, bif.out_act, bif.in_ready};
         check_eq("hold_stable", hold_obs, hold_exp);
      end
      bif.in_valid = 1'b0;
      accept_out();
      rand_wts();
      x = 16'($urandom);
      load_vec(x, 1'b0);
      finish_vec(x);
      accept_out();

      rand_wts();
      load_vec(16'($urandom), 1'b0);
      n = 0;
      while (!(bif.w_en && bif.w_addr == 3) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_addr3", {bif.w_en, bif.w_addr}, {1'b1, 3'd3});
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_in_ready", bif.in_ready, 1);
      check_eq("abort_out_valid", bif.out_valid, 0);
      check_eq("abort_w_en", bif.w_en, 0);
      rst = 1'b0;
      @(negedge clk);
      x = 16'($urandom);
      load_vec(x, 1'b0);
      finish_vec(x);
      accept_out();

      for (int v = 0; v < 2; v++) begin
         rand_wts();
         x = 16'($urandom);
         load_vec(x, 1'b1);
         finish_vec(x);
         accept_out();
      end

      for (int v = 0; v < 4; v++) begin
         rand_wts();
         if (v == 0) wts[3] = wts[1];
         x = 16'($urandom);
         load_vec(x, 1'($urandom));
         finish_vec(x);
         accept_out();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bnn_layer_engine.md
# bnn_layer_engine

Parametrised binarised fully-connected layer engine for the BNN medical classifier. Accepts a binarised feature vector as a byte stream, then serially evaluates XNOR-popcount for every output neuron against weights fetched from an external synchronous weight memory. Produces per-neuron sign activations, the winning class index (argmax) and its score. It replaces the fixed-size classifier datapath behind the TinyTapeout top level and runs at any input width, neuron count and fetch width.

## Interface
- IN_BITS, 64: feature vector length in bits; multiple of 8 and of CHUNK.
- NEURONS, 8: output neurons/classes; ≥2.
- CHUNK, 8: weight bits fetched and processed per cycle; 8, 16 or 32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  feature byte; first accepted byte = vector bits [7:0].
- in_valid  in  1  feature byte valid.
- in_ready  out  1  engine accepts a byte (high only in LOAD).
- w_addr  out  clog2(NEURONS*IN_BITS/CHUNK)  weight word address = j*CHUNKS + k.
- w_en  out  1  weight read strobe.
- w_data  in  CHUNK  weight word; valid exactly one cycle after w_en.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_class  out  clog2(NEURONS)  argmax neuron index.
- out_score  out  clog2(IN_BITS+1)  popcount of winning neuron.
- out_act  out  NEURONS  sign activation bitmap, bit j = neuron j.

## Operation
- Encoding: bit 1 = +1, bit 0 = −1; match = XNOR(input, weight). CHUNKS = IN_BITS/CHUNK. Chunk k = bits [k*CHUNK +: CHUNK].
- States: LOAD → COMPUTE → DONE → LOAD.
- LOAD: in_ready=1; each in_valid&in_ready edge writes the byte into the next 8-bit slot of the input register. After IN_BITS/8 accepted bytes → COMPUTE, byte counter cleared.
- COMPUTE: one w_en/w_addr per cycle, addresses 0..NEURONS*CHUNKS−1 in order. Each returned word is XNORed with its chunk, popcounted and summed into the neuron accumulator. The accumulator is cleared at each neuron's first chunk.
- At a neuron's last chunk, the final sum S_j is formed combinationally. Then out_act[j] <= (S_j ≥ IN_BITS/2). If j==0 or S_j > best_score, then best_score <= S_j and best_class <= j.
- Ties: the lowest index wins (strict >).
- After the last neuron's update → DONE.
- DONE: out_valid=1 with stable outputs. The out_valid&out_ready edge → LOAD and clears out_valid. in_valid is ignored outside LOAD (in_ready=0).
- Widths: popcount and accumulator are clog2(IN_BITS+1) bits and unsigned; no overflow is possible.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, w_en=0, w_addr=0, out_class=0, out_score=0, out_act=0, byte counter=0, accumulator=0.
- Reset during COMPUTE or DONE aborts the operation and discards the partial vector. The next cycle is LOAD.
- Let T be the edge accepting the last byte. Then w_en is high in cycles T+1 .. T+NC, where NC=NEURONS*CHUNKS. w_data is consumed in cycles T+2 .. T+NC+1. out_valid rises in cycle T+NC+2.
- Latency is NC+2 cycles from the last-byte accept edge to out_valid.
- Throughput: one vector per IN_BITS/8 + NC + 2 + (out_ready wait) cycles.
- The output handshake is standard valid/ready. Outputs must not change while out_valid=1 and out_ready=0.
- The weight memory has a fixed 1-cycle read latency with no stall. w_en is low in LOAD and DONE.

## Structure
- Package bnn_pkg: state enum (LOAD, COMPUTE, DONE), binary-encoding constants (POS=1, NEG=0), and width helper functions (clog2-based widths for score, class and address).
- Sub-module bnn_popcount (combinational, parameter W=CHUNK): returns clog2(W+1)-bit count of ones. The engine instantiates it once on XNOR(w_data, chunk).
- The engine holds the FSM, byte and address counters, a one-cycle-delayed neuron/chunk tag aligned with w_data, the accumulator and the argmax registers.

## Test plan
All scenarios use IN_BITS=16, NEURONS=4, CHUNK=8 and a bench weight ROM with 1-cycle latency.
- Input 0xFF,0xFF; weights n0=0x0000, n1=0x00FF, n2=0xFFFF, n3=0x0FFF → out_class=2, out_score=16, out_act=4'b1110, out_valid at 8+2 cycles after the last accept.
- Input 0x00,0x00; all weights 0x0000 → all scores 16 (tie) → out_class=0, out_score=16, out_act=4'b1111.
- Input 0xAA,0x55; n3=0x55AA, others 0x0000 → out_class=3, out_score=16. Check exactly 8 w_en pulses, addresses 0..7.
- Hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, extra in_valid bytes ignored. The next vector loads correctly after acceptance.
- Assert rst for one cycle mid-COMPUTE (address 3) → next cycle in_ready=1, out_valid=0, w_en=0. A fresh vector then gives the correct result.
- Back-to-back vectors with in_valid gapped every other cycle → both results correct, and no byte is lost or duplicated.
